// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle MIPS controller: state encoding, opcodes,
// datapath select encodings and the packed control-word struct.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       beq_or_bne;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: opcode/mem_ready toward the controller,
// control strobes and debug state back to the datapath.
interface mc_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BEQorBNE;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [3:0] state_o;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, BEQorBNE, PCSource, IorD, MemRead, MemWrite,
           IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, BEQorBNE, PCSource, IorD, MemRead, MemWrite,
           IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, state_o
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: state -> control word, purely combinational (0 latency).
// mem_go_i gates the FETCH write strobes while memory is stalling; rst_i kills all enables.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_e      state_i,
  input  logic        rst_i,
  input  logic        mem_go_i,
  input  logic [5:0]  opcode_q_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = mem_go_i;
        ctrl_o.pc_write  = mem_go_i;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADDR, S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.beq_or_bne    = (opcode_q_i == OP_BEQ);
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: begin
        ctrl_o = '0;
      end
    endcase

    // State is already FETCH during reset; only the architectural writes need killing.
    if (rst_i) begin
      ctrl_o.pc_write      = 1'b0;
      ctrl_o.pc_write_cond = 1'b0;
      ctrl_o.ir_write      = 1'b0;
      ctrl_o.mem_write     = 1'b0;
      ctrl_o.reg_write     = 1'b0;
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and opcode latch.
// Optional MC_MEM_WAIT_EN holds FETCH/MEMREAD/MEMWRITE until mem_ready; otherwise one cycle per state.
module mc_control
  import mc_pkg::*;
#(
  parameter int ILLEGAL_HALT = 1
) (
  input  logic     clk,
  input  logic     rst,
  mc_if.master     bus
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic       mem_go;
  ctrl_t      ctrl;

`ifdef MC_MEM_WAIT_EN
  assign mem_go = bus.mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      S_FETCH:    if (mem_go) state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = bus.opcode;
        case (bus.opcode)
          OP_LW, OP_SW:   state_d = S_MEMADDR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_ADDI_EX;
          default:        state_d = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADDR:  state_d = (opcode_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_go) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_go) state_d = S_FETCH;
      S_EXEC:     state_d = S_RWB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state_i    (state_q),
    .rst_i      (rst),
    .mem_go_i   (mem_go),
    .opcode_q_i (opcode_q),
    .ctrl_o     (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.BEQorBNE    = ctrl.beq_or_bne;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.state_o     = state_q;

endmodule
